// File: rtl/cb_addr_gen_pkg.sv
// Shared constants, FSM encoding and lane-mask helper for the CB address generator and shifter.
package cb_addr_gen_pkg;

  localparam int L             = 4;
  localparam int CB_AW         = 19;
  localparam int ROW_LEN       = 10;
  localparam int STATE_CNT_MAX = 5;
  localparam int ROW_STRIDE    = 6;
  localparam int SC_W          = $clog2(STATE_CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Low min(sc+1, L) lanes enabled.
  function automatic logic [L-1:0] lane_mask(input logic [SC_W-1:0] sc);
    logic [L-1:0] m;
    for (int i = 0; i < L; i++) m[i] = (i <= int'(sc));
    return m;
  endfunction

endpackage

// File: rtl/cb_slot_counter.sv
// Slot/group counter pair: walks STATE_CNT_MAX+1 slots per group up to a latched last group.
module cb_slot_counter
  import cb_addr_gen_pkg::*;
(
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               i_load,
  input  logic [ROW_LEN-1:0] i_last_grp,
  input  logic               i_advance,
  output logic [SC_W-1:0]    o_state_cnt,
  output logic               o_grp_lsb,
  output logic               o_slot_wrap,
  output logic               o_last_slot
);

  logic [SC_W-1:0]    r_state_cnt;
  logic [ROW_LEN-1:0] r_group_cnt;
  logic [ROW_LEN-1:0] r_last_grp;
  logic               w_slot_wrap;
  logic               w_last_grp_hit;

  assign w_slot_wrap    = (r_state_cnt == SC_W'(STATE_CNT_MAX));
  assign w_last_grp_hit = (r_group_cnt == r_last_grp);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      r_state_cnt <= '0;
      r_group_cnt <= '0;
      r_last_grp  <= '0;
    end else if (i_load) begin
      r_state_cnt <= '0;
      r_group_cnt <= '0;
      r_last_grp  <= i_last_grp;
    end else if (i_advance) begin
      if (w_slot_wrap) begin
        r_state_cnt <= '0;
        // Group counter parks on the last group, so an all-ones last group never overflows.
        if (!w_last_grp_hit) r_group_cnt <= r_group_cnt + 1'b1;
      end else begin
        r_state_cnt <= r_state_cnt + 1'b1;
      end
    end
  end

  assign o_state_cnt = r_state_cnt;
  assign o_grp_lsb   = r_group_cnt[0];
  assign o_slot_wrap = w_slot_wrap;
  assign o_last_slot = w_slot_wrap && w_last_grp_hit;

endmodule

// File: rtl/cb_addr_gen.sv
// Upstream address sequencer for the CB bank address shifter: FSM, row base accumulator, output registers.
module cb_addr_gen
  import cb_addr_gen_pkg::*;
(
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               stall,
  input  logic [ROW_LEN-1:0] landmark_num,
  input  logic [CB_AW-1:0]   base_addr,
  output logic [CB_AW-1:0]   din,
  output logic [L-1:0]       CB_en,
  output logic               group_cnt_0,
  output logic               busy,
  output logic               done
);

  state_e           r_state, w_state_nxt;
  logic [CB_AW-1:0] r_row_base;
  logic [CB_AW-1:0] r_din, w_din_nxt;
  logic [L-1:0]     r_cb_en, w_cb_en_nxt;
  logic             r_grp0, w_grp0_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_load, w_advance;
  logic [SC_W-1:0]  w_state_cnt;
  logic             w_grp_lsb, w_slot_wrap, w_last_slot;

  cb_slot_counter u_slot_counter (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .i_load      (w_load),
    .i_last_grp  (landmark_num),
    .i_advance   (w_advance),
    .o_state_cnt (w_state_cnt),
    .o_grp_lsb   (w_grp_lsb),
    .o_slot_wrap (w_slot_wrap),
    .o_last_slot (w_last_slot)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_din_nxt   = r_din;
    w_cb_en_nxt = r_cb_en;
    w_grp0_nxt  = r_grp0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_din_nxt   = '0;
        w_cb_en_nxt = '0;
        w_grp0_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          w_advance   = 1'b1;
          w_din_nxt   = r_row_base + CB_AW'(w_state_cnt);
          w_cb_en_nxt = lane_mask(w_state_cnt);
          w_grp0_nxt  = w_grp_lsb;
          w_busy_nxt  = 1'b1;
          if (w_last_slot) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_cb_en_nxt = '0;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      r_state    <= ST_IDLE;
      r_row_base <= '0;
      r_din      <= '0;
      r_cb_en    <= '0;
      r_grp0     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_din   <= w_din_nxt;
      r_cb_en <= w_cb_en_nxt;
      r_grp0  <= w_grp0_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_load) r_row_base <= base_addr;
      else if (w_advance && w_slot_wrap && !w_last_slot) r_row_base <= r_row_base + CB_AW'(ROW_STRIDE);
    end
  end

  assign din         = r_din;
  assign CB_en       = r_cb_en;
  assign group_cnt_0 = r_grp0;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_cb_addr_gen.sv
// Directed scoreboard bench for cb_addr_gen: expected per-cycle outputs are queued, then popped each cycle.
module tb_cb_addr_gen;
  import cb_addr_gen_pkg::*;

  typedef struct packed {
    logic [CB_AW-1:0] din;
    logic [L-1:0]     en;
    logic             g0;
    logic             busy;
    logic             done;
  } obs_t;

  logic               clk;
  logic               sys_rst;
  logic               start;
  logic               stall;
  logic [ROW_LEN-1:0] landmark_num;
  logic [CB_AW-1:0]   base_addr;
  logic [CB_AW-1:0]   din;
  logic [L-1:0]       CB_en;
  logic               group_cnt_0;
  logic               busy;
  logic               done;

  obs_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  cb_addr_gen dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .stall        (stall),
    .landmark_num (landmark_num),
    .base_addr    (base_addr),
    .din          (din),
    .CB_en        (CB_en),
    .group_cnt_0  (group_cnt_0),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_zero();
    obs_t e;
    e = '0;
    sb.push_back(e);
  endtask

  // Compare current outputs against the oldest expected entry.
  task automatic sample(input string tag);
    obs_t o, e;
    o = {din, CB_en, group_cnt_0, busy, done};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty, observed=%h", tag, o);
      return;
    end
    e = sb.pop_front();
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed din=%h en=%b g0=%b busy=%b done=%b expected din=%h en=%b g0=%b busy=%b done=%b",
             tag, o.din, o.en, o.g0, o.busy, o.done, e.din, e.en, e.g0, e.busy, e.done);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    @(negedge clk);
    sample(tag);
  endtask

  // Expected trace of one sequence: idle cycle after acceptance, every slot, done, back to idle.
  task automatic build_run(input int base, input int last, input int stall_k, input int stall_len,
                           output int n);
    obs_t e;
    int   k;
    n = 0;
    k = 0;
    e = '0;
    sb.push_back(e); n++;
    for (int g = 0; g <= last; g++) begin
      for (int s = 0; s <= STATE_CNT_MAX; s++) begin
        e.din  = CB_AW'(base + g * ROW_STRIDE + s);
        e.en   = (s + 1 >= L) ? {L{1'b1}} : L'((1 << (s + 1)) - 1);
        e.g0   = g[0];
        e.busy = 1'b1;
        e.done = 1'b0;
        sb.push_back(e); n++;
        if (k == stall_k) begin
          for (int r = 0; r < stall_len; r++) begin
            sb.push_back(e); n++;
          end
        end
        k++;
      end
    end
    e.en   = '0;
    e.done = 1'b1;
    sb.push_back(e); n++;
    e = '0;
    sb.push_back(e); n++;
  endtask

  task automatic run_seq(input string tag, input int base, input int last,
                         input int stall_k, input int stall_len, input bit ign_start);
    int n, done_idx;
    build_run(base, last, stall_k, stall_len, n);
    done_idx     = 1 + (last + 1) * (STATE_CNT_MAX + 1) + stall_len;
    landmark_num = ROW_LEN'(last);
    base_addr    = CB_AW'(base);
    for (int i = 0; i < n; i++) begin
      start = (i == 0) || (ign_start && (i == 5 || i == done_idx));
      stall = (stall_k >= 0) && (i >= stall_k + 2) && (i <= stall_k + 1 + stall_len);
      step(tag);
      if (i == 0) begin
        landmark_num = ROW_LEN'($urandom);
        base_addr    = CB_AW'($urandom);
      end
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    int n;
    sys_rst      = 1'b0;
    start        = 1'b0;
    stall        = 1'b0;
    landmark_num = '0;
    base_addr    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    push_zero();
    sample("reset");
    sys_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_zero();
      step("idle");
    end

    run_seq("basic",   'h100,   1, -1, 0, 1'b0);
    run_seq("stall",   'h100,   1,  2, 3, 1'b0);
    run_seq("wrap",    'h7FFFE, 0, -1, 0, 1'b0);
    run_seq("ignstart",'h100,   1, -1, 0, 1'b1);

    // Reset mid-run at group 1 / slot 3: outputs clear, no done, then a fresh run from group 0.
    build_run('h200, 1, -1, 0, n);
    landmark_num = 1;
    base_addr    = 'h200;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0);
      step("prerst");
    end
    start = 1'b0;
    sb.delete();
    sys_rst = 1'b0;
    push_zero();
    step("rst_mid");
    sys_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_zero();
      step("rst_idle");
    end
    run_seq("fresh",   'h300,   0, -1, 0, 1'b0);
    run_seq("maxgrp",  'h0,  (1 << ROW_LEN) - 1, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cb_addr_gen.md
Name: cb_addr_gen

Overview:
Upstream address sequencer for the CB bank address shifter.
- Per group, walks a fixed number of state slots over a run of landmark groups.
- Drives the BANK0 row address (din), the per-lane enable mask (CB_en) and group-parity (group_cnt_0) that the shifter consumes each cycle.
- Started by the covariance-update controller; signals busy/done back to it.

Parameters:
L, 4, number of CB banks/lanes (width of CB_en)
CB_AW, 19, CB address width
ROW_LEN, 10, width of landmark/group counters
STATE_CNT_MAX, 5, last state slot index per group (STATE_CNT_MAX+1 cycles per group)
ROW_STRIDE, 6, address increment between consecutive groups' BANK0 base

Ports:
clk  input  1  system clock, all logic on rising edge
sys_rst  input  1  synchronous reset, active-low (0 = reset)
start  input  1  one-cycle request to begin a sequence; sampled only in IDLE
stall  input  1  1 = freeze counters and hold all outputs (downstream back-pressure)
landmark_num  input  ROW_LEN  index of last group (groups run 0..landmark_num); latched on start
base_addr  input  CB_AW  BANK0 base address of group 0; latched on start
din  output  CB_AW  BANK0 row address to shifter
CB_en  output  L  lane enable mask to shifter
group_cnt_0  output  1  group_cnt[0] to shifter
busy  output  1  high from the cycle after start acceptance through the DONE cycle
done  output  1  one-cycle pulse after the last slot of the last group

Behaviour:
- Reset (sys_rst==0 at edge): state=IDLE; state_cnt, group_cnt, row_base, din, CB_en, group_cnt_0, busy, done all 0. Reset mid-sequence aborts immediately; no done pulse.
- All outputs registered; no combinational input-to-output path.
- FSM states:
  - IDLE: if start, latch landmark_num→last_grp and base_addr→row_base; clear state_cnt and group_cnt; go RUN. Outputs are 0 in IDLE.
  - RUN: each non-stalled cycle:
    - din = row_base + state_cnt.
    - CB_en = low min(state_cnt+1, L) bits set.
    - group_cnt_0 = group_cnt[0].
    - busy = 1.
  - RUN state_cnt wrap: when state_cnt==STATE_CNT_MAX, state_cnt←0.
    - If group_cnt==last_grp, go DONE.
    - Otherwise group_cnt+1 and row_base+ROW_STRIDE.
  - DONE: one cycle with done=1, busy=1, CB_en=0, din holds its last value. Then IDLE.
- Latency: start sampled at edge t → first RUN outputs valid after edge t+1. Total busy cycles = (last_grp+1)*(STATE_CNT_MAX+1) + 1 with no stalls.
- stall=1 in RUN: state_cnt, group_cnt, row_base and all outputs hold. stall is ignored in IDLE and DONE; DONE always lasts exactly one cycle.
- start while busy: ignored, no restart.
- start and DONE in the same cycle: ignored. A new start is accepted only in IDLE.
- Address arithmetic is modulo 2^CB_AW; wrap past all-ones is silent.
- group_cnt is ROW_LEN wide; landmark_num = 2^ROW_LEN-1 is legal and must terminate without overflow.
- landmark_num=0: exactly one group. group_cnt_0 stays 0 throughout.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DONE), default L, CB_AW, ROW_LEN, STATE_CNT_MAX and ROW_STRIDE constants used by both this block and the shifter.
- One natural sub-module: cb_slot_counter.
  - Holds state_cnt and group_cnt, with stall, wrap and last-group detect.
  - The top level holds the FSM, row_base accumulator and output registers.

Test Plan:
- Reset then idle: hold sys_rst=0 3 cycles, release, no start → all outputs 0, busy=0 for 10 cycles.
- Basic run, base_addr=0x100, landmark_num=1:
  - din runs 0x100..0x105 with CB_en 0001,0011,0111,1111,1111,1111 and group_cnt_0=0.
  - Then din 0x106..0x10B with group_cnt_0=1.
  - done pulses at the 13th busy cycle.
- Stall: same run with stall=1 for 3 cycles at state_cnt=2 of group 0 → din holds 0x102 and CB_en 0111 for the stalled cycles, then resumes at 0x103. done is delayed exactly 3 cycles.
- Address wrap: base_addr=0x7FFFE, landmark_num=0 → din = 0x7FFFE, 0x7FFFF, 0x00000..0x00003.
- Ignored start: pulse start again mid-run and in the DONE cycle → sequence unchanged, single done pulse, returns to IDLE.
- Reset mid-run: assert sys_rst=0 at group 1, state_cnt 3 → next cycle all outputs 0, no done. A fresh start afterwards runs from group 0.
